prbs18_checker: RTL and testbench
=================================

// Module: prbs18_checker
// PURPOSE
//  Serial checker downstream of the 18-bit Fibonacci LFSR (x^18+x^11+1, all-ones seed).
//  Consumes the generator's 'out' bit stream, self-synchronises to it and declares lock.
//  Once locked, flags and counts every bit that violates the recurrence s[k] = s[k-11] ^ s[k-18].
//  Used as the loopback/BIST sink for the LFSR generator.
// PARAMETERS
//  LOCK_THRESH  32    consecutive correct predictions required in SEARCH to declare lock (1..255)
//  CNT_W        16    width of err_count, saturating
//  WIN_LEN      1024  relock observation window in valid bits (PRBS_CHK_RELOCK_EN only)
//  RELOCK_ERRS  16    errors within one window that force loss of lock (PRBS_CHK_RELOCK_EN only)
// PORTS
//  clock      in   1      single clock, all state updates on posedge
//  clear      in   1      synchronous, active-high reset
//  in         in   1      serial data bit (generator 'out')
//  in_valid   in   1      'in' sampled only on edges where in_valid=1
//  locked     out  1      1 while in LOCKED state
//  err        out  1      one-cycle pulse: last sampled bit mispredicted while locked
//  err_count  out  CNT_W  total errors since clear, saturates at 2^CNT_W-1
// BEHAVIOUR
//  - Reset: clear=1 at an edge -> hist=0, fill=0, match_cnt=0, state=SEARCH, locked=0, err=0,
//    err_count=0. clear has priority over in_valid; the bit on that edge is discarded.
//  - hist[18:1]: last 18 received bits, hist[1] newest. Every valid edge shifts 'in' into
//    hist[1], in both states. The received bit is always loaded, never the prediction.
//  - fill counts 0..18 valid bits after clear or relock. pred = hist[11]^hist[18], used only
//    when fill==18. Bits 0..17 after clear are fill only: no compare, no err.
//  - SEARCH: on a valid edge with fill==18:
//    match   -> match_cnt++ unless hist==0. All-zero history never counts, so a stuck-at-0 input
//               never locks.
//    mismatch -> match_cnt=0. No err pulse, no err_count change.
//    match_cnt reaching LOCK_THRESH -> LOCKED. locked is registered: high from the cycle after
//    that edge.
//  - LOCKED: on each valid edge compare 'in' with pred.
//    mismatch -> err=1 for exactly the following cycle; err_count+1 unless already saturated.
//    A single flipped line bit gives 3 err pulses: at that bit, 11 bits later and 18 bits later.
//  - in_valid=0: no state change; err returns to 0 on the next edge.
//  - Latency: err and locked are registered, 1 cycle after the sampling edge. No combinational
//    path from in to any output.
//  - Leaving LOCKED happens only by clear, or by relock when the macro is enabled.
//    match_cnt is held while LOCKED.
// CONFIGURATION
//  PRBS_CHK_RELOCK_EN defined:
//    - In LOCKED, a WIN_LEN valid-bit window counts errors; the window restarts on wrap.
//    - When the window error count reaches RELOCK_ERRS: state=SEARCH, locked=0 next cycle,
//      fill=0, match_cnt=0.
//    - err_count is preserved across a relock. The error that hits the threshold still pulses
//      err and is counted.
//  PRBS_CHK_RELOCK_EN undefined: no window logic; LOCKED persists until clear.
//    WIN_LEN and RELOCK_ERRS are unused.
// TESTING
//  1 Generator and checker cleared together, in_valid=1 -> locked=1 from the cycle after the edge
//    sampling bit 49 (18 fill + 32 matches). err=0 and err_count=0 over 10000 bits.
//  2 Locked, invert bit 1000 only -> err pulses after bits 1000, 1011 and 1018; err_count=3;
//    stays locked.
//  3 in held 0 for 500 valid bits -> locked=0, err=0, err_count=0 throughout.
//  4 in_valid 1-of-3 duty, generator enabled on the same cycles -> lock after valid bit 49;
//    no errors.
//  5 clear pulsed while locked with err_count=3 -> next cycle locked=0, err_count=0;
//    relocks 50 valid bits later.
//  6 CNT_W=4, random input after lock:
//    - macro off: locked stays 1; err_count saturates at 15.
//    - macro on, WIN_LEN=64, RELOCK_ERRS=8: locked=0 one cycle after the 8th error in window.

Source files
------------

// File: rtl/prbs18_checker.sv
// -----------------------------------------------------------------------------
// prbs18_checker
//
// Purpose:
//   Serial checker for the output of an 18-bit Fibonacci LFSR (x^18 + x^11 + 1,
//   all-ones seed). It self-synchronises by loading the received bits into a
//   history register. It predicts each new bit from that history and declares
//   lock after LOCK_THRESH consecutive correct predictions. Once locked, it
//   flags and counts every bit that breaks the recurrence
//   s[k] = s[k-11] ^ s[k-18].
//
// Parameters:
//   LOCK_THRESH  consecutive correct predictions needed to lock (1..255)
//   CNT_W        width of the saturating err_count
//   WIN_LEN      relock observation window in valid bits (>= 2)
//   RELOCK_ERRS  errors in one window that force loss of lock (>= 1)
//
// Ports:
//   clock      in   1      single clock, everything updates on posedge
//   clear      in   1      synchronous active-high reset, beats in_valid
//   in         in   1      serial data bit from the generator
//   in_valid   in   1      'in' is sampled only when this is high
//   locked     out  1      high while in the LOCKED state (registered)
//   err        out  1      one-cycle pulse after a mispredicted bit in LOCKED
//   err_count  out  CNT_W  errors since clear, saturating at all-ones
//
// Configuration:
//   PRBS_CHK_RELOCK_EN  when defined, a WIN_LEN-bit window counts errors in
//                       LOCKED. Reaching RELOCK_ERRS drops back to SEARCH and
//                       restarts the fill. When undefined, LOCKED is left only
//                       through clear.
// -----------------------------------------------------------------------------
module prbs18_checker #(
    parameter int LOCK_THRESH = 32,
    parameter int CNT_W       = 16,
    parameter int WIN_LEN     = 1024,
    parameter int RELOCK_ERRS = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in,
    input  logic             in_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [7:0]       THRESH     = 8'(LOCK_THRESH);
    localparam logic [4:0]       FILL_FULL  = 5'd18;

    state_t      state;
    logic [17:0] hist;        // hist[0] is the newest bit, hist[17] the oldest
    logic [4:0]  fill;
    logic [7:0]  match_cnt;

    logic        pred;
    logic        mismatch;
    logic        hist_zero;
    logic        fill_done;
    logic [7:0]  match_next;

    // The taps 11 and 18 bits back sit at hist[10] and hist[17].
    assign pred       = hist[10] ^ hist[17];
    assign mismatch   = in ^ pred;
    assign hist_zero  = (hist == 18'd0);
    assign fill_done  = (fill == FILL_FULL);
    assign match_next = match_cnt + 8'd1;

`ifdef PRBS_CHK_RELOCK_EN
    localparam int                WIN_W     = $clog2(WIN_LEN);
    localparam int                WERR_W    = $clog2(RELOCK_ERRS + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(RELOCK_ERRS - 1);

    logic [WIN_W-1:0]  win_pos;
    logic [WERR_W-1:0] win_errs;
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(WIN_LEN), 32'(RELOCK_ERRS)};
`endif

    // A single state machine register block. The received bit always goes
    // into the history, never the prediction, so one corrupted line bit
    // produces a mispredict at that bit, 11 bits later and 18 bits later.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= SEARCH;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
`ifdef PRBS_CHK_RELOCK_EN
            win_pos   <= '0;
            win_errs  <= '0;
`endif
        end else begin
            err <= 1'b0;
            if (in_valid) begin
                hist <= {hist[16:0], in};
                if (!fill_done) begin
                    fill <= fill + 5'd1;
                end else begin
                    case (state)
                        SEARCH: begin
                            // An all-zero history predicts 0 trivially, so a
                            // stuck-at-0 line must not build up matches.
                            if (!mismatch) begin
                                if (!hist_zero) begin
                                    match_cnt <= match_next;
                                    if (match_next == THRESH) begin
                                        state  <= LOCKED;
                                        locked <= 1'b1;
`ifdef PRBS_CHK_RELOCK_EN
                                        win_pos  <= '0;
                                        win_errs <= '0;
`endif
                                    end
                                end
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                        LOCKED: begin
                            if (mismatch) begin
                                err <= 1'b1;
                                if (err_count != CNT_MAX) begin
                                    err_count <= err_count + 1'b1;
                                end
                            end
`ifdef PRBS_CHK_RELOCK_EN
                            // The error that reaches the threshold is still
                            // reported and counted above; err_count survives.
                            if (mismatch && (win_errs == WERR_LAST)) begin
                                state     <= SEARCH;
                                locked    <= 1'b0;
                                fill      <= '0;
                                match_cnt <= '0;
                                win_pos   <= '0;
                                win_errs  <= '0;
                            end else if (win_pos == WIN_LAST) begin
                                win_pos  <= '0;
                                win_errs <= '0;
                            end else begin
                                win_pos  <= win_pos + 1'b1;
                                win_errs <= win_errs + WERR_W'(mismatch);
                            end
`endif
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs18_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs18_checker
//
// Purpose:
//   Self-checking bench for prbs18_checker. A behavioural model keeps the
//   received bits in a queue and applies the recurrence directly. A negedge
//   process compares locked/err/err_count against the model every cycle, and
//   literal checks pin the lock point, the error pulses and saturation.
//   The DUT is built with CNT_W=4 so that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_prbs18_checker;

    localparam int CNT_W       = 4;
    localparam int LOCK_THRESH = 32;
    localparam int CNT_MAX     = 15;

    logic             clock    = 1'b0;
    logic             clear    = 1'b1;
    logic             in_bit   = 1'b0;
    logic             in_valid = 1'b0;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    prbs18_checker #(
        .LOCK_THRESH(LOCK_THRESH),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .clear(clear),
        .in(in_bit),
        .in_valid(in_valid),
        .locked(locked),
        .err(err),
        .err_count(err_count)
    );

    // Behavioural model: the last 18 received bits as a queue
    // (front = oldest). It is updated on the same edge the DUT samples.
    bit rx[$];
    int m_matches = 0;
    bit m_locked  = 1'b0;
    bit m_err     = 1'b0;
    int m_count   = 0;

    always @(posedge clock) begin
        if (clear) begin
            rx.delete();
            m_matches = 0;
            m_locked  = 1'b0;
            m_err     = 1'b0;
            m_count   = 0;
        end else begin
            m_err = 1'b0;
            if (in_valid) begin
                if (rx.size() == 18) begin
                    // rx[17] is 1 bit back, so k-11 is rx[7] and k-18 is rx[0].
                    bit expect_bit;
                    int ones;
                    expect_bit = rx[7] ^ rx[0];
                    ones = 0;
                    foreach (rx[i]) ones += int'(rx[i]);
                    if (!m_locked) begin
                        if (in_bit == expect_bit) begin
                            if (ones != 0) m_matches++;
                            if (m_matches == LOCK_THRESH) m_locked = 1'b1;
                        end else begin
                            m_matches = 0;
                        end
                    end else if (in_bit != expect_bit) begin
                        m_err = 1'b1;
                        if (m_count < CNT_MAX) m_count++;
                    end
                end
                rx.push_back(in_bit);
                if (rx.size() > 18) void'(rx.pop_front());
            end
        end
    end

    // Generator: a real Fibonacci LFSR, x^18 + x^11 + 1, seeded with all ones.
    logic [17:0] gen_state;

    task automatic genReset();
        gen_state = '1;
    endtask

    task automatic genBit(output logic b);
        logic fb;
        b  = gen_state[17];
        fb = gen_state[17] ^ gen_state[10];
        gen_state = {gen_state[16:0], fb};
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compares the DUT against the model on every cycle.
    always @(negedge clock) begin
        if (check_en) begin
            checkOutput("model_locked", int'(locked), int'(m_locked));
            checkOutput("model_err", int'(err), int'(m_err));
            checkOutput("model_err_count", int'(err_count), m_count);
        end
    end

    // Drives one cycle of inputs. The DUT samples them on the next posedge.
    task automatic applyStimulus(input logic c, input logic b, input logic v);
        clear    = c;
        in_bit   = b;
        in_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic literal(input string name, input int actual, input int expected);
        @(negedge clock);
        checkOutput(name, actual, expected);
    endtask

    initial begin
        logic b;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 1'b0);
        check_en = 1'b1;
        @(negedge clock);
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_err_count", int'(err_count), 0);

        // Clean stream: lock after bit index 49, no errors over 10000 bits.
        genReset();
        for (int k = 0; k < 10000; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1);
            if (k == 48) begin @(negedge clock); checkOutput("lock_not_yet", int'(locked), 0); end
            if (k == 49) begin @(negedge clock); checkOutput("lock_at_49", int'(locked), 1); end
        end
        @(negedge clock);
        checkOutput("clean_err_count", int'(err_count), 0);
        checkOutput("clean_locked", int'(locked), 1);

        // A single inverted line bit gives three error pulses.
        applyStimulus(1'b1, 1'b0, 1'b0);
        genReset();
        for (int k = 0; k < 1100; k++) begin
            genBit(b);
            applyStimulus(1'b0, b ^ (k == 1000), 1'b1);
            if (k == 1000 || k == 1011 || k == 1018) begin
                @(negedge clock);
                checkOutput("flip_err_pulse", int'(err), 1);
            end
            if (k == 1001) begin @(negedge clock); checkOutput("flip_err_gap", int'(err), 0); end
        end
        @(negedge clock);
        checkOutput("flip_err_count", int'(err_count), 3);
        checkOutput("flip_still_locked", int'(locked), 1);

        // Clear while locked, with a valid bit on the same edge.
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(negedge clock);
        checkOutput("clear_locked", int'(locked), 0);
        checkOutput("clear_err_count", int'(err_count), 0);

        // Relock with in_valid at a 1-of-3 duty. Random data on idle cycles.
        genReset();
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b0, 1'($urandom), 1'b0);
            applyStimulus(1'b0, 1'($urandom), 1'b0);
            genBit(b);
            applyStimulus(1'b0, b, 1'b1);
            if (k == 48) begin @(negedge clock); checkOutput("duty_not_yet", int'(locked), 0); end
            if (k == 49) begin @(negedge clock); checkOutput("duty_lock_49", int'(locked), 1); end
        end
        @(negedge clock);
        checkOutput("duty_err_count", int'(err_count), 0);

        // Stuck-at-0 input never locks.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 500; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("zero_locked", int'(locked), 0);
        checkOutput("zero_err_count", int'(err_count), 0);

        // Random data after lock: err_count saturates and lock holds.
        applyStimulus(1'b1, 1'b0, 1'b0);
        genReset();
        for (int k = 0; k < 60; k++) begin
            genBit(b);
            applyStimulus(1'b0, b, 1'b1);
        end
        for (int k = 0; k < 400; k++) applyStimulus(1'b0, 1'($urandom), 1'($urandom_range(0, 1)));
        @(negedge clock);
        checkOutput("sat_err_count", int'(err_count), CNT_MAX);
        checkOutput("sat_locked", int'(locked), 1);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
